// File: rtl/mxp_relu_nch.sv
// mxp_relu_nch: streaming KxK max-pool + ReLU over NUM_CH packed channels, raster-order input.
// Define MXP_RELU_LEAKY_EN for a leaky activation (negatives scaled by 1/8 via >>>3).
module mxp_relu_nch #(
  parameter int DATA_W    = 12,
  parameter int NUM_CH    = 3,
  parameter int IN_WIDTH  = 24,
  parameter int IN_HEIGHT = 24,
  parameter int POOL      = 2,
  parameter int COL_BIT   = 5,
  parameter int ROW_BIT   = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic                     valid_out,
  output logic                     frame_done
);
  localparam int OW  = IN_WIDTH / POOL;
  localparam int WC  = OW * POOL;
  localparam int HC  = (IN_HEIGHT / POOL) * POOL;
  localparam int PW  = POOL > 2 ? 2 : 1;
  localparam int OCW = OW > 1 ? $clog2(OW) : 1;
  localparam int DW  = NUM_CH * DATA_W;
  logic [COL_BIT-1:0] col;
  logic [ROW_BIT-1:0] row;
  logic [OCW-1:0]     oc;
  logic [PW-1:0]      pc, pr;
  logic [DW-1:0]      hmax, hmax_nx, cand, act_v;
  logic [DW-1:0]      lbuf [OW];
  logic               in_win, win_end, row_end, last_row, pool_out;
  assign in_win   = ({1'b0, col} < (COL_BIT+1)'(WC)) && ({1'b0, row} < (ROW_BIT+1)'(HC));
  assign win_end  = in_win && pc == PW'(POOL-1);
  assign row_end  = col == COL_BIT'(IN_WIDTH-1);
  assign last_row = row == ROW_BIT'(IN_HEIGHT-1);
  assign pool_out = win_end && pr == PW'(POOL-1);
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic signed [DATA_W-1:0] x, h, hn, l, cd;
    assign x  = in_data[c*DATA_W +: DATA_W];
    assign h  = hmax[c*DATA_W +: DATA_W];
    assign l  = lbuf[oc][c*DATA_W +: DATA_W];
    assign hn = (pc == '0 || x > h) ? x : h;
    assign cd = (pr == '0 || hn > l) ? hn : l;
    assign hmax_nx[c*DATA_W +: DATA_W] = hn;
    assign cand[c*DATA_W +: DATA_W]    = cd;
`ifdef MXP_RELU_LEAKY_EN
    assign act_v[c*DATA_W +: DATA_W] = cd[DATA_W-1] ? cd >>> 3 : cd;
`else
    assign act_v[c*DATA_W +: DATA_W] = cd[DATA_W-1] ? '0 : cd;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      oc         <= '0;
      pc         <= '0;
      pr         <= '0;
      hmax       <= '0;
      out_data   <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (valid_in) begin
        if (in_win) begin
          hmax <= hmax_nx;
          pc   <= win_end ? '0 : pc + PW'(1);
          if (win_end) oc <= oc == OCW'(OW-1) ? '0 : oc + OCW'(1);
        end
        if (pool_out) begin
          out_data   <= act_v;
          valid_out  <= 1'b1;
          frame_done <= oc == OCW'(OW-1) && row == ROW_BIT'(HC-1);
        end
        col <= row_end ? '0 : col + COL_BIT'(1);
        if (row_end) begin
          row <= last_row ? '0 : row + ROW_BIT'(1);
          pr  <= (last_row || pr == PW'(POOL-1)) ? '0 : pr + PW'(1);
          pc  <= '0;
          oc  <= '0;
        end
      end
    end
  end
  // Only partial-row maxima are stored; the pr==0 pass overwrites stale entries, so no reset.
  always_ff @(posedge clk)
    if (valid_in && win_end && pr != PW'(POOL-1)) lbuf[oc] <= cand;
endmodule

// File: tb/tb_mxp_relu_nch.sv
// tb_mxp_relu_nch: directed scoreboard bench over three pool/map configurations.
module tb_mxp_relu_nch;
  typedef struct {
    logic [35:0] d;
    logic        fd;
    int          cyc;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  vin = '0;
  logic [35:0] din = '0;
  logic [35:0] oa;
  logic [11:0] ob, oc2;
  logic        va, fa, vb, fb, vc, fc;
  int          n_chk = 0, n_err = 0, cyc = 0;
  exp_t        q0[$], q1[$], q2[$];
  bit          rst_q;
  logic [35:0] last_a = '0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end
  mxp_relu_nch #(.DATA_W(12), .NUM_CH(3), .IN_WIDTH(4), .IN_HEIGHT(4), .POOL(2),
                 .COL_BIT(2), .ROW_BIT(2)) u_a (
    .clk(clk), .rst(rst), .valid_in(vin[0]), .in_data(din), .out_data(oa),
    .valid_out(va), .frame_done(fa));
  mxp_relu_nch #(.DATA_W(12), .NUM_CH(1), .IN_WIDTH(5), .IN_HEIGHT(5), .POOL(2),
                 .COL_BIT(3), .ROW_BIT(3)) u_b (
    .clk(clk), .rst(rst), .valid_in(vin[1]), .in_data(din[11:0]), .out_data(ob),
    .valid_out(vb), .frame_done(fb));
  mxp_relu_nch #(.DATA_W(12), .NUM_CH(1), .IN_WIDTH(6), .IN_HEIGHT(6), .POOL(3),
                 .COL_BIT(3), .ROW_BIT(3)) u_c (
    .clk(clk), .rst(rst), .valid_in(vin[2]), .in_data(din[11:0]), .out_data(oc2),
    .valid_out(vc), .frame_done(fc));
  function automatic logic [35:0] pk(int a, int b, int c);
    return {12'(c), 12'(b), 12'(a)};
  endfunction
  task automatic chk(string nm, logic [35:0] got, logic [35:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  task automatic send(int d, logic [35:0] data, bit e, logic [35:0] ex, bit fd);
    exp_t x;
    @(negedge clk);
    vin    = '0;
    vin[d] = 1'b1;
    din    = data;
    x.d    = ex;
    x.fd   = fd;
    x.cyc  = cyc + 1;
    if (e) begin
      if (d == 0) q0.push_back(x);
      else if (d == 1) q1.push_back(x);
      else q2.push_back(x);
    end
  endtask
  task automatic idle();
    @(negedge clk);
    vin = '0;
  endtask
  task automatic mon(int d, logic vo, logic fd, logic [35:0] got);
    exp_t e;
    if (fd === 1'b1 && vo !== 1'b1) chk($sformatf("dut%0d_fd_without_valid", d), {35'b0, fd}, 36'd0);
    if (vo === 1'b1) begin
      n_chk++;
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0) || (d == 2 && q2.size() == 0)) begin
        n_err++;
        $display("FAIL dut%0d_unexpected_output got=%h", d, got);
      end else begin
        e = d == 0 ? q0.pop_front() : d == 1 ? q1.pop_front() : q2.pop_front();
        if (got !== e.d || fd !== e.fd || cyc != e.cyc) begin
          n_err++;
          $display("FAIL dut%0d_output got=%h fd=%b cyc=%0d exp=%h fd=%b cyc=%0d",
                   d, got, fd, cyc, e.d, e.fd, e.cyc);
        end
      end
    end
  endtask
  always @(negedge clk) begin
    mon(0, va, fa, oa);
    mon(1, vb, fb, {24'b0, ob});
    mon(2, vc, fc, {24'b0, oc2});
    if (rst_q == 1'b0 && va === 1'b0) chk("dut0_hold", oa, last_a);
    last_a = oa;
  end
  int e1[4] = '{5, 7, 13, 15};
  int p2[4] = '{6, 8, 14, 16};
`ifdef MXP_RELU_LEAKY_EN
  int l1[4] = '{0, -1, -1, -2};
  int n2[4] = '{-1, -1, -2, -2};
  int c2    = -13;
`else
  int l1[4] = '{0, 0, 0, 0};
  int n2[4] = '{0, 0, 0, 0};
  int c2    = 0;
`endif
  initial begin
    int k;
    bit e;
    repeat (2) @(negedge clk);
    chk("rst_a_data", oa, '0);
    chk("rst_a_valid", {35'b0, va}, '0);
    chk("rst_a_fd", {35'b0, fa}, '0);
    chk("rst_b_valid", {35'b0, vb}, '0);
    chk("rst_c_data", {24'b0, oc2}, '0);
    rst = 1'b0;
    for (int f = 0; f < 2; f++) begin
      k = 0;
      for (int i = 0; i < 16; i++) begin
        e = i == 5 || i == 7 || i == 13 || i == 15;
        if (f == 0) send(0, pk(i, -i, 100), e, pk(e1[k], l1[k], 100), k == 3);
        else send(0, pk(-(i+1), i+1, -100), e, pk(n2[k], p2[k], c2), k == 3);
        if (e) k++;
      end
    end
    for (int i = 0; i < 5; i++) send(0, pk(500, 500, 500), 0, '0, 0);
    @(negedge clk);
    vin = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_a_data", oa, '0);
    chk("midrst_a_valid", {35'b0, va}, '0);
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 16; i++) begin
      e = i == 5 || i == 7 || i == 13 || i == 15;
      send(0, pk(i, -i, 100), e, pk(e1[k], l1[k], 100), k == 3);
      if (e) k++;
      if (i % 3 == 2) idle();
    end
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++) begin
          e = c < 4 && r < 4 && c % 2 == 1 && r % 2 == 1;
          send(1, (c < 4 && r < 4) ? 36'(r*4 + c) : 36'd1000, e, 36'(r*4 + c), c == 3 && r == 3);
          idle();
        end
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 36; i++) begin
        e = (i % 6) % 3 == 2 && (i / 6) % 3 == 2;
        send(2, 36'(i), e, 36'(i), i == 35);
      end
    repeat (4) idle();
    chk("q0_drained", 36'(q0.size()), '0);
    chk("q1_drained", 36'(q1.size()), '0);
    chk("q2_drained", 36'(q2.size()), '0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
